// File: rtl/fifo_ram.sv
// fifo_ram: FIFO storage array with one synchronous write port and one combinational read port
module fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [DEPTH-1:0] wr_addr,
   input  logic [DEPTH-1:0] rd_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);
   localparam int N = 1 << DEPTH;
   logic [WIDTH-1:0] mem_q [N];
   logic [WIDTH-1:0] mem_d [N];
   always_comb begin
      for (int i = 0; i < N; i++)
         mem_d[i] = (wr_en && wr_addr == DEPTH'(i)) ? wr_data : mem_q[i];
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         mem_q[i] <= rst ? '0 : mem_d[i];
   end
   assign rd_data = mem_q[rd_addr];
endmodule

// File: tb/tb_fifo_ram.sv
// tb_fifo_ram: randomized checks of fifo_ram against an array model of the storage
module tb_fifo_ram;
   logic       clk = 0;
   logic       rst = 0;
   logic       wr_en = 0;
   logic [3:0] wr_addr = 0;
   logic [3:0] rd_addr = 0;
   logic [7:0] wr_data = 0;
   logic [7:0] rd_data;
   logic [7:0] model [16];
   int vectors = 0;
   int errors = 0;

   fifo_ram #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .rd_addr(rd_addr), .wr_data(wr_data), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: rd_addr=%0d got=%h expected=%h", tag, rd_addr, got, exp);
      end
   endtask

   // one rising edge; the model applies the reset/write rule with the inputs held across it
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) model[i] = 8'h00;
      end else if (wr_en) begin
         model[wr_addr] = wr_data;
      end
      #1;
   endtask

   task automatic write(input logic [3:0] a, input logic [7:0] d);
      wr_addr = a; wr_data = d; wr_en = 1;
      tick();
      wr_en = 0;
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         check(tag, rd_data, 8'h00);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      #1;
      rst = 1;
      repeat (5) tick();
      rst = 0;
      sweep("reset_clear");

      for (int a = 0; a < 16; a++) begin
         write(4'(a), 8'($urandom));
         tick();
      end
      for (int k = 0; k < 100; k++) begin
         rd_addr = 4'($urandom_range(0, 15));
         #1;
         check("readback", rd_data, model[rd_addr]);
         tick();
      end

      write(4'd3, 8'h5A);
      wr_addr = 4'd3; wr_data = 8'hFF; wr_en = 0; rd_addr = 4'd3;
      repeat (4) tick();
      check("wr_disable", rd_data, 8'h5A);

      write(4'd7, 8'h11);
      rd_addr = 4'd7; wr_addr = 4'd7; wr_data = 8'h22; wr_en = 1;
      #1;
      check("collide_pre", rd_data, 8'h11);
      tick();
      wr_en = 0;
      check("collide_post", rd_data, 8'h22);

      write(4'd9, 8'h3C);
      rd_addr = 4'd9; wr_addr = 4'd2; wr_data = 8'hA5; wr_en = 1;
      #1;
      check("concurrent_pre", rd_data, 8'h3C);
      tick();
      wr_en = 0;
      check("concurrent_post", rd_data, 8'h3C);
      rd_addr = 4'd2;
      #1;
      check("concurrent_wr", rd_data, 8'hA5);

      for (int k = 0; k < 300; k++) begin
         rst = ($urandom_range(0, 39) == 0);
         wr_en = $urandom_range(0, 1) == 1;
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = 8'($urandom);
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         #1;
         check("mixed_pre", rd_data, model[rd_addr]);
         tick();
         check("mixed_post", rd_data, model[rd_addr]);
      end
      rst = 0; wr_en = 0;

      for (int a = 0; a < 16; a++) write(4'(a), 8'($urandom_range(1, 255)));
      rst = 1; wr_en = 1; wr_addr = 4'd4; wr_data = 8'h77;
      tick();
      rst = 0; wr_en = 0;
      sweep("reset_midop");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
